be_cycle_sequencer: RTL and testbench

- Converts an arbitrary active-low 4-bit byte-enable request from a 32-bit bus initiator (PCI/DMA bridge) into a sequence of legal MC68040 transfers.
- Each transfer is driven as A[1:0]/SIZ[1:0] with a TSn start strobe, and the block waits for TAn/TEAn termination before the next one.
- It is the encode direction of the byte-lane decode used on the CPU side: byte lanes in, size/address cycles out.
- It sits between the initiator's request port and the local 68040 bus cycle logic.

---
 rtl/be_cycle_sequencer_pkg.sv | 24 ++
 rtl/be_cycle_sequencer_chunk_pick.sv | 51 +++++
 rtl/be_cycle_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_be_cycle_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/be_cycle_sequencer_pkg.sv
// Shared definitions for the byte-enable to MC68040 cycle sequencer.
//   - SIZ encodings driven on the 68040 SIZ[1:0] pins
//   - sequencer state enumeration
//   - byte-lane bit indices (bit order matches BEn/LANEn)
package be_cycle_sequencer_pkg;

  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_BYTE = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitAck,
    StComplete
  } state_e;

  // Lane index in BEn/LANEn/REM; UU is the byte at A=00, LL the byte at A=11.
  localparam int unsigned LANE_UU = 3;
  localparam int unsigned LANE_UM = 2;
  localparam int unsigned LANE_LM = 1;
  localparam int unsigned LANE_LL = 0;

endpackage

// File: rtl/be_cycle_sequencer_chunk_pick.sv
// be_chunk_pick: combinational chunk picker.
// Chooses the next legal 68040 transfer from the mask of byte lanes still to be
// served, lowest address first, widest legal size at that address.
// Ports:
//   rem_i   [3:0]  active-high remaining lanes (UU..LL)
//   addr_o  [1:0]  A[1:0] of the chosen transfer
//   siz_o   [1:0]  SIZ code of the chosen transfer
//   lane_o  [3:0]  active-high lanes covered by the chosen transfer
module be_chunk_pick
  import be_cycle_sequencer_pkg::*;
(
  input  logic [3:0] rem_i,
  output logic [1:0] addr_o,
  output logic [1:0] siz_o,
  output logic [3:0] lane_o
);

  always_comb begin
    addr_o = 2'b00;
    siz_o  = SIZ_LONG;
    lane_o = 4'b0000;
    if (rem_i == 4'b1111) begin
      lane_o = 4'b1111;
    end else if (rem_i[LANE_UU] && rem_i[LANE_UM]) begin
      siz_o           = SIZ_WORD;
      lane_o[LANE_UU] = 1'b1;
      lane_o[LANE_UM] = 1'b1;
    end else if (rem_i[LANE_UU]) begin
      siz_o           = SIZ_BYTE;
      lane_o[LANE_UU] = 1'b1;
    end else if (rem_i[LANE_UM]) begin
      addr_o          = 2'b01;
      siz_o           = SIZ_BYTE;
      lane_o[LANE_UM] = 1'b1;
    end else if (rem_i[LANE_LM] && rem_i[LANE_LL]) begin
      addr_o          = 2'b10;
      siz_o           = SIZ_WORD;
      lane_o[LANE_LM] = 1'b1;
      lane_o[LANE_LL] = 1'b1;
    end else if (rem_i[LANE_LM]) begin
      addr_o          = 2'b10;
      siz_o           = SIZ_BYTE;
      lane_o[LANE_LM] = 1'b1;
    end else if (rem_i[LANE_LL]) begin
      addr_o          = 2'b11;
      siz_o           = SIZ_BYTE;
      lane_o[LANE_LL] = 1'b1;
    end
  end

endmodule

// File: rtl/be_cycle_sequencer.sv
// be_cycle_sequencer: turns one arbitrary active-low byte-enable request into a
// sequence of legal MC68040 transfers (A/SIZ/TSn), waiting for TAn/TEAn on each.
// Ports:
//   CLK40, RESETn (async, active low)
//   START, BEn[3:0]           request strobe and active-low byte enables
//   TAn, TEAn                 transfer acknowledge / error acknowledge
//   A[1:0], SIZ[1:0], TSn, TIPn, LANEn[3:0]   68040 cycle outputs (registered)
//   BUSY, DONE, ERR           request status (registered)
// Optional: define BE_ACK_TIMEOUT_EN to add an acknowledge watchdog; the
// TIMEOUT_CYCLES parameter exists only in that build.
module be_cycle_sequencer
  import be_cycle_sequencer_pkg::*;
`ifdef BE_ACK_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic       CLK40,
  input  logic       RESETn,
  input  logic       START,
  input  logic [3:0] BEn,
  input  logic       TAn,
  input  logic       TEAn,
  output logic [1:0] A,
  output logic [1:0] SIZ,
  output logic       TSn,
  output logic       TIPn,
  output logic [3:0] LANEn,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  state_e     state_q, state_d;
  logic [3:0] rem_q, rem_d;
  logic [1:0] a_q, a_d, siz_q, siz_d;
  logic [3:0] lanen_q, lanen_d;
  logic       tsn_q, tsn_d, tipn_q, tipn_d;
  logic       busy_q, busy_d, done_q, done_d, err_q, err_d;
  // Set while ISSUE is spending its idle-bus gap cycle after an acknowledge.
  logic       gap_q, gap_d;

  logic [3:0] pick_src, pick_lane, rem_left;
  logic [1:0] pick_a, pick_siz;
  logic       abort;

`ifdef BE_ACK_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  assign abort = !TEAn || (cnt_q == TimeoutLast);
`else
  assign abort = !TEAn;
`endif

  // In IDLE the chunk is picked straight from the incoming enables so the
  // first TSn follows START by a single cycle.
  assign pick_src = (state_q == StIdle) ? ~BEn : rem_q;
  // LANEn is the active-low mask of the lanes being served right now.
  assign rem_left = rem_q & lanen_q;

  be_chunk_pick u_pick (
    .rem_i  (pick_src),
    .addr_o (pick_a),
    .siz_o  (pick_siz),
    .lane_o (pick_lane)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    a_d     = a_q;
    siz_d   = siz_q;
    lanen_d = lanen_q;
    tsn_d   = 1'b1;
    tipn_d  = tipn_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    gap_d   = gap_q;
`ifdef BE_ACK_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (START) begin
          rem_d  = ~BEn;
          busy_d = 1'b1;
          if (BEn == 4'b1111) begin
            state_d = StComplete;
            done_d  = 1'b1;
          end else begin
            state_d = StIssue;
            gap_d   = 1'b0;
            tsn_d   = 1'b0;
            tipn_d  = 1'b0;
            a_d     = pick_a;
            siz_d   = pick_siz;
            lanen_d = ~pick_lane;
          end
        end
      end
      StIssue: begin
        if (gap_q) begin
          gap_d   = 1'b0;
          tsn_d   = 1'b0;
          tipn_d  = 1'b0;
          a_d     = pick_a;
          siz_d   = pick_siz;
          lanen_d = ~pick_lane;
        end else begin
          state_d = StWaitAck;
`ifdef BE_ACK_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      StWaitAck: begin
        if (abort) begin
          state_d = StComplete;
          rem_d   = 4'b0000;
          done_d  = 1'b1;
          err_d   = 1'b1;
          tipn_d  = 1'b1;
          lanen_d = 4'b1111;
        end else if (!TAn) begin
          rem_d   = rem_left;
          tipn_d  = 1'b1;
          lanen_d = 4'b1111;
          if (rem_left != 4'b0000) begin
            state_d = StIssue;
            gap_d   = 1'b1;
          end else begin
            state_d = StComplete;
            done_d  = 1'b1;
          end
        end else begin
`ifdef BE_ACK_TIMEOUT_EN
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      StComplete: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK40 or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= StIdle;
      rem_q   <= 4'b0000;
      a_q     <= 2'b00;
      siz_q   <= SIZ_LONG;
      lanen_q <= 4'b1111;
      tsn_q   <= 1'b1;
      tipn_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      gap_q   <= 1'b0;
`ifdef BE_ACK_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      a_q     <= a_d;
      siz_q   <= siz_d;
      lanen_q <= lanen_d;
      tsn_q   <= tsn_d;
      tipn_q  <= tipn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      gap_q   <= gap_d;
`ifdef BE_ACK_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign A     = a_q;
  assign SIZ   = siz_q;
  assign TSn   = tsn_q;
  assign TIPn  = tipn_q;
  assign LANEn = lanen_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_be_cycle_sequencer.sv
// Bench for be_cycle_sequencer. Requests are expanded by a transaction-level
// model into a per-cycle script of inputs and expected outputs; one compare
// process checks the DUT against the script on every falling edge.
module tb_be_cycle_sequencer;

  logic       CLK40 = 1'b0;
  logic       RESETn;
  logic       START;
  logic [3:0] BEn;
  logic       TAn, TEAn;
  logic [1:0] A, SIZ;
  logic       TSn, TIPn, BUSY, DONE, ERR;
  logic [3:0] LANEn;

  always #5 CLK40 = ~CLK40;

`ifdef BE_ACK_TIMEOUT_EN
  be_cycle_sequencer #(.TIMEOUT_CYCLES(4)) dut (
`else
  be_cycle_sequencer dut (
`endif
    .CLK40  (CLK40),
    .RESETn (RESETn),
    .START  (START),
    .BEn    (BEn),
    .TAn    (TAn),
    .TEAn   (TEAn),
    .A      (A),
    .SIZ    (SIZ),
    .TSn    (TSn),
    .TIPn   (TIPn),
    .LANEn  (LANEn),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .ERR    (ERR)
  );

  typedef struct {
    logic       start;
    logic [3:0] ben;
    logic       tan, tean;
    logic       tsn, tipn;
    logic [3:0] lanen;
    logic [1:0] a, siz;
    logic       busy, done, err;
  } step_t;

  step_t script[$];
  step_t cur;
  logic  chk_en = 1'b0;
  int    n_cmp  = 0;
  int    n_bad  = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic r1();
    return 1'($urandom);
  endfunction

  function automatic logic [3:0] r4();
    return 4'($urandom);
  endfunction

  // Legal transfers in service order; the first one wholly inside the
  // remaining mask is the next transfer.
  function automatic void model_pick(input logic [3:0] rem, output logic [1:0] a,
                                     output logic [1:0] siz, output logic [3:0] m);
    logic [3:0] masks[7];
    logic [1:0] addrs[7];
    logic [1:0] sizes[7];
    masks = '{4'b1111, 4'b1100, 4'b1000, 4'b0100, 4'b0011, 4'b0010, 4'b0001};
    addrs = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11};
    sizes = '{2'b00, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
    m = 4'b0000; a = 2'b00; siz = 2'b00;
    for (int i = 0; i < 7; i++) begin
      if (m == 4'b0000 && (rem & masks[i]) == masks[i]) begin
        m = masks[i]; a = addrs[i]; siz = sizes[i];
      end
    end
  endfunction

  task automatic add(input logic st, input logic [3:0] ben, input logic tan, input logic tean,
                     input logic tsn, input logic tipn, input logic [3:0] lanen,
                     input logic [1:0] a, input logic [1:0] siz,
                     input logic busy, input logic done, input logic err);
    step_t s;
    s.start = st; s.ben = ben; s.tan = tan; s.tean = tean;
    s.tsn = tsn; s.tipn = tipn; s.lanen = lanen; s.a = a; s.siz = siz;
    s.busy = busy; s.done = done; s.err = err;
    script.push_back(s);
  endtask

  // err_at: index of the transfer terminated by TEAn (-1 or out of range: none).
  task automatic build_req(input logic [3:0] ben, input int err_at, input logic err_ta,
                           input int dmax);
    logic [3:0] rem, m;
    logic [1:0] a, siz;
    int         idx, d;
    rem = ~ben;
    add(1'b1, ben, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    if (rem == 4'b0000) begin
      add(r1(), r4(), 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
      return;
    end
    idx = 0;
    while (rem != 4'b0000) begin
      model_pick(rem, a, siz, m);
      // Termination inputs are random here: they must be ignored in the TSn cycle.
      add(r1(), r4(), r1(), r1(), 1'b0, 1'b0, ~m, a, siz, 1'b1, 1'b0, 1'b0);
      d = int'($urandom_range(dmax));
      repeat (d) add(r1(), r4(), 1'b1, 1'b1, 1'b1, 1'b0, ~m, a, siz, 1'b1, 1'b0, 1'b0);
      if (idx == err_at) begin
        add(r1(), r4(), err_ta, 1'b0, 1'b1, 1'b0, ~m, a, siz, 1'b1, 1'b0, 1'b0);
        add(r1(), r4(), 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1);
        return;
      end
      add(r1(), r4(), 1'b0, 1'b1, 1'b1, 1'b0, ~m, a, siz, 1'b1, 1'b0, 1'b0);
      rem = rem & ~m;
      idx++;
      if (rem != 4'b0000)
        add(r1(), r4(), 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    end
    add(r1(), r4(), 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic run_script();
    while (script.size() > 0) begin
      @(posedge CLK40);
      #1;
      cur   = script.pop_front();
      START = cur.start;
      BEn   = cur.ben;
      TAn   = cur.tan;
      TEAn  = cur.tean;
      chk_en = 1'b1;
    end
    @(posedge CLK40);
    #1;
    chk_en = 1'b0;
    START  = 1'b0;
    TAn    = 1'b1;
    TEAn   = 1'b1;
  endtask

  task automatic check_reset_vals();
    check("rst_A", {2'b00, A}, 4'b0000);
    check("rst_SIZ", {2'b00, SIZ}, 4'b0000);
    check("rst_TSn", {3'b000, TSn}, 4'b0001);
    check("rst_TIPn", {3'b000, TIPn}, 4'b0001);
    check("rst_LANEn", LANEn, 4'b1111);
    check("rst_BUSY", {3'b000, BUSY}, 4'b0000);
    check("rst_DONE", {3'b000, DONE}, 4'b0000);
    check("rst_ERR", {3'b000, ERR}, 4'b0000);
  endtask

  // Compare process: every cycle the script is active.
  always @(negedge CLK40) begin
    if (chk_en) begin
      check("TSn", {3'b000, TSn}, {3'b000, cur.tsn});
      check("TIPn", {3'b000, TIPn}, {3'b000, cur.tipn});
      check("LANEn", LANEn, cur.lanen);
      check("BUSY", {3'b000, BUSY}, {3'b000, cur.busy});
      check("DONE", {3'b000, DONE}, {3'b000, cur.done});
      check("ERR", {3'b000, ERR}, {3'b000, cur.err});
      if (!cur.tipn) begin
        check("A", {2'b00, A}, {2'b00, cur.a});
        check("SIZ", {2'b00, SIZ}, {2'b00, cur.siz});
      end
    end
  end

  initial begin
    logic [3:0] m;
    logic [1:0] a, siz;
    RESETn = 1'b0;
    START  = 1'b0;
    BEn    = 4'hF;
    TAn    = 1'b1;
    TEAn   = 1'b1;
    repeat (2) @(posedge CLK40);
    #2;
    check_reset_vals();
    RESETn = 1'b1;

    // Pin the reference picker to hand-worked cases.
    model_pick(4'b1111, a, siz, m); check("pick1111", {a, siz}, 4'b0000); check("m1111", m, 4'b1111);
    model_pick(4'b1110, a, siz, m); check("pick1110", {a, siz}, 4'b0010); check("m1110", m, 4'b1100);
    model_pick(4'b0111, a, siz, m); check("pick0111", {a, siz}, 4'b0101); check("m0111", m, 4'b0100);
    model_pick(4'b0011, a, siz, m); check("pick0011", {a, siz}, 4'b1010); check("m0011", m, 4'b0011);
    model_pick(4'b0010, a, siz, m); check("pick0010", {a, siz}, 4'b1001); check("m0010", m, 4'b0010);
    model_pick(4'b0001, a, siz, m); check("pick0001", {a, siz}, 4'b1101); check("m0001", m, 4'b0001);

    // Directed requests.
    add(1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    build_req(4'b0000, -1, 1'b1, 3);
    build_req(4'b0101, -1, 1'b1, 2);
    build_req(4'b1100, -1, 1'b1, 1);
    build_req(4'b0001, -1, 1'b1, 0);
    build_req(4'b1111, -1, 1'b1, 0);
    build_req(4'b0110, 0, 1'b1, 2);
    build_req(4'b0110, 0, 1'b0, 0);
    build_req(4'b1010, 1, 1'b0, 1);
`ifdef BE_ACK_TIMEOUT_EN
    add(1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    repeat (4) add(1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1);
`endif
    run_script();

    // Randomized requests with random waits, errors and ignored strobes.
    for (int i = 0; i < 60; i++) begin
      build_req(r4(), ($urandom_range(4) == 0) ? int'($urandom_range(3)) : -1, r1(), 3);
      if (r1()) add(1'b0, r4(), r1(), r1(), 1'b1, 1'b1, 4'hF, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    end
    run_script();

    // Unacknowledged transfer: BUSY must hold, then async reset mid-cycle.
    @(posedge CLK40);
    #1;
    START = 1'b1;
    BEn   = 4'b0110;
    @(posedge CLK40);
    #1;
    START = 1'b0;
`ifdef BE_ACK_TIMEOUT_EN
    repeat (2) begin
`else
    repeat (20) begin
`endif
      @(posedge CLK40);
      #2;
      check("hang_BUSY", {3'b000, BUSY}, 4'b0001);
      check("hang_TIPn", {3'b000, TIPn}, 4'b0000);
    end
    RESETn = 1'b0;
    #1;
    check_reset_vals();
    @(posedge CLK40);
    #1;
    RESETn = 1'b1;

    // After reset the block must accept new requests from a clean state.
    build_req(4'b1111, -1, 1'b1, 0);
    build_req(4'b1001, -1, 1'b1, 2);
    run_script();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
